// File: rtl/pmp_csr_programmer_pkg.sv
// Shared types, CSR addresses and lane helpers for the PMP CSR programmer.
package pmp_csr_programmer_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REGION_W  = 4;
    localparam int unsigned SIZE_W    = 6;
    localparam int unsigned CFG_W     = 8;

    localparam logic [XLEN-1:0] CSR_PMPCFG0  = 32'h0000_03A0;
    localparam logic [XLEN-1:0] CSR_PMPADDR0 = 32'h0000_03B0;

    typedef enum logic [1:0] {
        PMP_OFF,
        PMP_TOR,
        PMP_NA4,
        PMP_NAPOT
    } pmp_mode_e;

    typedef enum logic [1:0] {
        PMP_OK,
        PMP_LOCKED,
        PMP_MISMATCH,
        PMP_BADARG
    } pmp_status_e;

    // One pmpcfg byte lane
    typedef struct packed {
        logic      lock;
        logic [1:0] rsvd;
        pmp_mode_e mode;
        logic [2:0] perm;
    } pmp_cfg_t;

    // Region descriptor as presented on the request port
    typedef struct packed {
        logic [REGION_W-1:0] region;
        pmp_mode_e           mode;
        logic [XLEN-1:0]     base;
        logic [SIZE_W-1:0]   size_log2;
        logic [2:0]          perm;
        logic                lock;
    } pmp_req_t;

    // Extract byte lane 'lane' of a pmpcfg word
    function automatic logic [CFG_W-1:0] lane_get(input logic [XLEN-1:0] word,
                                                  input logic [1:0] lane);
        lane_get = word[{lane, 3'b000} +: CFG_W];
    endfunction

    // Replace byte lane 'lane' of a pmpcfg word, keeping the others
    function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] word,
                                                   input logic [1:0] lane,
                                                   input logic [CFG_W-1:0] lane_val);
        logic [XLEN-1:0] merged;
        merged = word;
        merged[{lane, 3'b000} +: CFG_W] = lane_val;
        lane_merge = merged;
    endfunction

endpackage

// File: rtl/pmp_csr_programmer_addr_encoder.sv
// Combinational pmpaddr encoder with argument legality check.
module pmp_addr_encoder
    import pmp_csr_programmer_pkg::*;
(
    input  pmp_mode_e         mode,
    input  logic [XLEN-1:0]   base,
    input  logic [SIZE_W-1:0] size_log2,
    output logic [XLEN-1:0]   pmpaddr,
    output logic              badarg
);

    logic [XLEN:0]   align_mask;
    logic [XLEN-1:0] napot_ones;

    // Encode the address register value and flag illegal alignment or size
    always_comb begin
        pmpaddr    = {2'b00, base[XLEN-1:2]};
        badarg     = 1'b0;
        align_mask = (33'd1 << size_log2) - 33'd1;
        napot_ones = (32'd1 << (size_log2 - 6'd3)) - 32'd1;
        case (mode)
            PMP_TOR, PMP_NA4: begin
                badarg = (base[1:0] != 2'b00);
            end
            PMP_NAPOT: begin
                if ((size_log2 < 6'd3) || (size_log2 > 6'd32)) begin
                    badarg = 1'b1;
                end else begin
                    badarg  = (({1'b0, base} & align_mask) != 33'd0);
                    pmpaddr = {2'b00, base[XLEN-1:2]} | napot_ones;
                end
            end
            default: begin
                badarg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pmp_csr_programmer.sv
// Programs one PMP region per request via read-modify-write of pmpcfg and verify read-back.
module pmp_csr_programmer
    import pmp_csr_programmer_pkg::*;
#(
    parameter logic [1:0] PRIV_M = 2'b00
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [REGION_W-1:0] req_region,
    input  logic [1:0]          req_mode,
    input  logic [XLEN-1:0]     req_base,
    input  logic [SIZE_W-1:0]   req_size_log2,
    input  logic [2:0]          req_perm,
    input  logic                req_lock,
    output logic                rsp_valid,
    output logic [1:0]          rsp_status,
    output logic                wr_en,
    output logic [1:0]          priv_mode,
    output logic [XLEN-1:0]     rw_addr,
    output logic [XLEN-1:0]     wdata,
    input  logic [XLEN-1:0]     rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CFG,
        S_CHK,
        S_WR_ADDR,
        S_WR_CFG,
        S_VFY_ADDR,
        S_VFY_CFG,
        S_RESP
    } state_e;

    state_e              state;
    pmp_req_t            req;
    pmp_cfg_t            req_cfg;
    logic [XLEN-1:0]     enc_addr;
    logic                enc_badarg;

    logic [REGION_W-1:0] region_q;
    logic [CFG_W-1:0]    cfg_byte_q;
    logic [XLEN-1:0]     addr_q;
    logic [XLEN-1:0]     cfg_word_q;
    logic                mismatch_q;

    logic [XLEN-1:0]     cfg_csr;
    logic [XLEN-1:0]     addr_csr;

    assign priv_mode = PRIV_M;

    // Bundle the request port into a descriptor
    assign req = '{region:    req_region,
                   mode:      pmp_mode_e'(req_mode),
                   base:      req_base,
                   size_log2: req_size_log2,
                   perm:      req_perm,
                   lock:      req_lock};

    // New cfg byte built from the live descriptor, latched on acceptance
    assign req_cfg = '{lock: req.lock, rsvd: 2'b00, mode: req.mode, perm: req.perm};

    // CSR addresses owned by the latched region
    assign cfg_csr  = CSR_PMPCFG0  + XLEN'(region_q[3:2]);
    assign addr_csr = CSR_PMPADDR0 + XLEN'(region_q);

    pmp_addr_encoder u_enc (
        .mode      (req.mode),
        .base      (req.base),
        .size_log2 (req.size_log2),
        .pmpaddr   (enc_addr),
        .badarg    (enc_badarg)
    );

    // Sequencer: state and all CSR/response outputs registered together
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= PMP_OK;
            wr_en      <= 1'b0;
            rw_addr    <= CSR_PMPCFG0;
            wdata      <= '0;
            region_q   <= '0;
            cfg_byte_q <= '0;
            addr_q     <= '0;
            cfg_word_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            wr_en     <= 1'b0;
            wdata     <= '0;
            rw_addr   <= CSR_PMPCFG0;
            req_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        region_q   <= req.region;
                        cfg_byte_q <= req_cfg;
                        addr_q     <= enc_addr;
                        mismatch_q <= 1'b0;
                        if (enc_badarg) begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= PMP_BADARG;
                        end else begin
                            state   <= S_RD_CFG;
                            rw_addr <= CSR_PMPCFG0 + XLEN'(req.region[3:2]);
                        end
                    end
                end
                S_RD_CFG: begin
                    cfg_word_q <= rdata;
                    state      <= S_CHK;
                end
                S_CHK: begin
                    if (lane_get(cfg_word_q, region_q[1:0]) >= 8'h80) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= PMP_LOCKED;
                    end else begin
                        state   <= S_WR_ADDR;
                        wr_en   <= 1'b1;
                        rw_addr <= addr_csr;
                        wdata   <= addr_q;
                    end
                end
                S_WR_ADDR: begin
                    state   <= S_WR_CFG;
                    wr_en   <= 1'b1;
                    rw_addr <= cfg_csr;
                    wdata   <= lane_merge(cfg_word_q, region_q[1:0], cfg_byte_q);
                end
                S_WR_CFG: begin
                    state   <= S_VFY_ADDR;
                    rw_addr <= addr_csr;
                end
                S_VFY_ADDR: begin
                    if (rdata != addr_q) begin
                        mismatch_q <= 1'b1;
                    end
                    state   <= S_VFY_CFG;
                    rw_addr <= cfg_csr;
                end
                S_VFY_CFG: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    if (mismatch_q || (lane_get(rdata, region_q[1:0]) != cfg_byte_q)) begin
                        rsp_status <= PMP_MISMATCH;
                    end else begin
                        rsp_status <= PMP_OK;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pmp_csr_programmer.md
# pmp_csr_programmer

CSR-side initiator for `pmp_registers`: it accepts one PMP region descriptor per handshake and drives the `wr_en`/`rw_addr`/`wdata`/`priv_mode` port that the register file responds to. For each region it encodes the address register, does a read-modify-write of the owning `pmpcfgN` byte lane, and reads both registers back to verify. Boot firmware shims and the security monitor use it to program regions without hand-building CSR sequences.

## Interface
Parameters:
- PRIV_M, 2'b00, privilege code driven on `priv_mode`; it matches the M-mode encoding of `pmp_registers`.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  descriptor valid
- req_ready  out  1  high only in IDLE while reset is low
- req_region  in  4  region index 0..15
- req_mode  in  2  A field: 0 OFF, 1 TOR, 2 NA4, 3 NAPOT
- req_base  in  32  byte base address (TOR: top address)
- req_size_log2  in  6  log2 of region bytes; NAPOT only, legal 3..32
- req_perm  in  3  {X,W,R}
- req_lock  in  1  L bit
- rsp_valid  out  1  one-cycle pulse with status
- rsp_status  out  2  0 OK, 1 LOCKED, 2 MISMATCH, 3 BADARG
- wr_en  out  1  CSR write strobe
- priv_mode  out  2  constant PRIV_M
- rw_addr  out  32  CSR address
- wdata  out  32  CSR write data
- rdata  in  32  CSR read data; combinational from `rw_addr`, sampled at the end of the cycle

## Operation
- **Address encoding:**
  - TOR and NA4: pmpaddr = base[31:2]; base[1:0] must be 0.
  - NAPOT: pmpaddr = (base >> 2) | ((1 << (size_log2-3)) - 1). base must be 2^size_log2 aligned.
  - Illegal base alignment or size, or NAPOT size outside 3..32, gives BADARG.
  - OFF: pmpaddr = base[31:2], no alignment check.
- **Config byte:** {lock, 2'b00, mode, X, W, R}. It goes to word `CSR_PMPCFG0 + region[3:2]`, lane `region[1:0]` (bits 8·lane+7 : 8·lane). Other lanes are preserved from the read.
- **FSM states:**
  - IDLE: accept a request. Descriptor fields are latched. BADARG goes to RESP; otherwise go to RD_CFG.
  - RD_CFG: `rw_addr` = cfg word, `wr_en` = 0; capture `rdata`.
  - CHK: if the L bit in the captured lane is set, go to RESP with LOCKED.
  - WR_ADDR: write pmpaddr to `CSR_PMPADDR0 + region`. The address is written before the cfg byte, so a newly set lock cannot block it.
  - WR_CFG: write the merged cfg word.
  - VFY_ADDR: read pmpaddr and compare.
  - VFY_CFG: read the cfg word and compare the lane.
  - RESP: `rsp_valid` = 1, then return to IDLE.
- **Verify result:** any verify mismatch reports MISMATCH; otherwise OK.
- **CSR idle value:** `wr_en` is high only in WR_ADDR and WR_CFG. In all other states `wdata` = 0 and `rw_addr` = `CSR_PMPCFG0`.
- **Input sampling:** requests arriving while `req_ready` = 0 are ignored. The latched descriptor is immune to input changes after acceptance.

## Timing
- **Reset values:** `wr_en` = 0, `rw_addr` = `CSR_PMPCFG0`, `wdata` = 0, `rsp_valid` = 0, `rsp_status` = 0, `req_ready` = 0. `priv_mode` = PRIV_M always.
- **Latency**, with acceptance at edge E0:
  - BADARG: `rsp_valid` in the cycle after E0.
  - LOCKED: `rsp_valid` in the cycle after E2 (RD_CFG then CHK).
  - OK or MISMATCH: `rsp_valid` in the cycle after E6. `wr_en` is high in the cycles ending at E3 and E4.
- **Throughput:** `req_ready` rises the cycle after RESP, giving at most one request per 8 cycles on the full path.
- **Reset mid-operation:** state returns to IDLE asynchronously and `wr_en` drops immediately. No `rsp_valid` is issued. A partially programmed region is acceptable.

## Structure
- **cep_define additions:**
  - `typedef enum logic [1:0] pmp_mode_e {PMP_OFF, PMP_TOR, PMP_NA4, PMP_NAPOT}`
  - `typedef enum logic [1:0] pmp_status_e {PMP_OK, PMP_LOCKED, PMP_MISMATCH, PMP_BADARG}`
  - Existing CSR address constants are reused.
- **Local:** the FSM state enum stays inside this module.
- **Sub-module:** `pmp_addr_encoder`, a combinational unit that takes mode, base and size and produces the pmpaddr value and a BADARG flag.

## Test plan
- **NAPOT OK:** region 5, NAPOT, base 0x8000_0000, size 12, perm 3'b011, unlocked.
  - Writes: `CSR_PMPADDR0+5` ← 0x2000_01FF, then `CSR_PMPCFG1` lane 1 = 0x1B with the other lanes unchanged.
  - Response: OK 7 cycles after acceptance.
- **NAPOT misaligned:** base 0x8000_0100, size 12 → BADARG the next cycle, no `wr_en` pulse.
- **NA4 misaligned:** base 0x0000_1002 → BADARG.
- **Locked region:** program region 0 with lock = 1 (OK), then reprogram region 0 → LOCKED 3 cycles after acceptance, zero writes.
- **TOR lock blocks address:** program region 2 as TOR locked, then region 1 with NA4 base 0x1000.
  - The register file ignores the pmpaddr1 write, so the response is MISMATCH.
- **Reset mid-operation:** assert reset during WR_CFG → `wr_en` = 0 within the same cycle, no `rsp_valid`, `req_ready` = 1 one cycle after release.
